kmap_eval: RTL and testbench

- Registered Karnaugh-map function evaluator holding two truth-table functions side by side.
- f4 is the 4-variable map (inputs a,b,c,d); f5 is the 5-variable map (inputs a,b,c,d,e).
- Both functions are table-driven with reset-loaded default tables, and either table can be rewritten at run time.
- Sits as a small combinational-logic demo/utility block behind one clock domain.

---
 rtl/kmap_pkg.sv | 19 +
 rtl/kmap_lut.sv | 56 +++++
 rtl/kmap_eval.sv | 86 ++++++++
 tb/tb_kmap_eval.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/kmap_pkg.sv
// -----------------------------------------------------------------------------
// kmap_pkg
// Shared constants for the Karnaugh-map evaluator: default truth tables,
// index widths and the table-select encoding used by the write port.
// -----------------------------------------------------------------------------
package kmap_pkg;

  // Default 4-variable table: f4 = b XNOR d, i.e. minterms 0,2,5,7,8,10,13,15.
  localparam logic [15:0] K4_DEFAULT = 16'hA5A5;
  // Default 5-variable table: f5 = c'.e + a.d'.
  localparam logic [31:0] K5_DEFAULT = 32'h3B3B0A0A;

  localparam int IDX4_W = 4;
  localparam int IDX5_W = 5;

  localparam logic TBL_SEL_K4 = 1'b0;
  localparam logic TBL_SEL_K5 = 1'b1;

endpackage : kmap_pkg

// File: rtl/kmap_lut.sv
// -----------------------------------------------------------------------------
// kmap_lut
// One N-variable truth-table lookup: a 2^N-bit table register with a write
// port and a registered output bit.
//
// Ports:
//   clk    in        rising-edge clock
//   rst_n  in        async active-low reset; table -> INIT, output -> 0
//   idx    in  [N]   map index, MSB = first variable
//   we     in        table write strobe
//   wdata  in  [2^N] new table contents
//   q      out       registered table[idx]
// -----------------------------------------------------------------------------
module kmap_lut #(
  parameter int                N    = 4,
  parameter logic [2**N-1:0]   INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      idx,
  input  logic              we,
  input  logic [2**N-1:0]   wdata,
  output logic              q
);

  logic [2**N-1:0] tbl_d, tbl_q;
  logic            out_d, out_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    tbl_d = tbl_q;
    if (we) begin
      tbl_d = wdata;
    end
    // The lookup reads the current (old) table, so a write on the same edge
    // only affects the sample taken at the following edge.
    out_d = tbl_q[idx];
  end

  // NOTE: the table is a small register bank, not a RAM, so it is reset like
  // any other flop; that is what restores the default function on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= INIT;
      out_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      tbl_q <= tbl_d;
      out_q <= out_d;
    end
  end

  assign q = out_q;

endmodule : kmap_lut

// File: rtl/kmap_eval.sv
// -----------------------------------------------------------------------------
// kmap_eval
// Registered Karnaugh-map evaluator holding a 4-variable function (f4) and a
// 5-variable function (f5) side by side. Both are table-driven, reset to
// default tables and rewritable at run time. One cycle of latency.
//
// Ports:
//   clk, rst_n       clock / async active-low reset
//   a,b,c,d          map variables, a = MSB
//   e                5th variable, f5 only, LSB of the 5-var index
//   tbl_we           table write strobe (one cycle)
//   tbl_sel          0 = 4-var table, 1 = 5-var table
//   tbl_wdata [32]   new table; only [15:0] used for the 4-var table
//   f4, f5           registered map results
//   valid            high from the first edge after reset release
// -----------------------------------------------------------------------------
module kmap_eval
  import kmap_pkg::*;
#(
  parameter logic [15:0] K4_INIT = K4_DEFAULT,
  parameter logic [31:0] K5_INIT = K5_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        tbl_we,
  input  logic        tbl_sel,
  input  logic [31:0] tbl_wdata,
  output logic        f4,
  output logic        f5,
  output logic        valid
);

  logic [IDX4_W-1:0] idx4;
  logic [IDX5_W-1:0] idx5;
  logic              we4, we5;
  logic              valid_d, valid_q;

  always_comb begin
    idx4    = {a, b, c, d};
    idx5    = {a, b, c, d, e};
    // Exactly one table is targeted per write.
    we4     = tbl_we && (tbl_sel == TBL_SEL_K4);
    we5     = tbl_we && (tbl_sel == TBL_SEL_K5);
    valid_d = 1'b1;
  end

  kmap_lut #(
    .N    (IDX4_W),
    .INIT (K4_INIT)
  ) u_lut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (idx4),
    .we    (we4),
    .wdata (tbl_wdata[15:0]),
    .q     (f4)
  );

  kmap_lut #(
    .N    (IDX5_W),
    .INIT (K5_INIT)
  ) u_lut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (idx5),
    .we    (we5),
    .wdata (tbl_wdata),
    .q     (f5)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

endmodule : kmap_eval

// File: tb/tb_kmap_eval.sv
// -----------------------------------------------------------------------------
// tb_kmap_eval
// Directed self-checking bench for kmap_eval.
// -----------------------------------------------------------------------------
module tb_kmap_eval;

  logic        clk;
  logic        rst_n;
  logic        a, b, c, d, e;
  logic        tbl_we;
  logic        tbl_sel;
  logic [31:0] tbl_wdata;
  logic        f4, f5, valid;

  int tests_run;
  int tests_failed;

  // Reference tables, written out independently of the design package.
  logic [15:0] ref4;
  logic [31:0] ref5;

  kmap_eval dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .tbl_we    (tbl_we),
    .tbl_sel   (tbl_sel),
    .tbl_wdata (tbl_wdata),
    .f4        (f4),
    .f5        (f5),
    .valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic apply(input logic [4:0] v);
    {a, b, c, d, e} = v;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ref4         = 16'hA5A5;
    ref5         = 32'h3B3B0A0A;
    rst_n        = 1'b0;
    tbl_we       = 1'b0;
    tbl_sel      = 1'b0;
    tbl_wdata    = '0;
    apply(5'b00000);

    // Reset state
    repeat (2) step();
    check("rst_f4", f4, 1'b0);
    check("rst_f5", f5, 1'b0);
    check("rst_valid", valid, 1'b0);

    // Release away from the edge; valid must wait for the first edge.
    #2;
    rst_n = 1'b1;
    apply(5'b10110);  // a=1,b=0,c=1,d=1,e=0
    #1;
    check("pre_edge_valid", valid, 1'b0);
    step();
    check("v1_valid", valid, 1'b1);
    check("v1_f4_idx11", f4, 1'b0);
    check("v1_f5_idx22", f5, 1'b0);

    apply(5'b01101);
    step();
    check("v2_f4_idx6", f4, 1'b0);
    check("v2_f5_idx13", f5, 1'b0);

    apply(5'b11011);
    step();
    check("v3_f4_idx13", f4, 1'b1);
    check("v3_f5_idx27", f5, 1'b1);

    apply(5'b10000);
    step();
    check("v4_f4_idx8", f4, 1'b1);
    check("v4_f5_idx16", f5, 1'b1);

    // Sweep all 32 combinations against the reference tables.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = i[4:0];
      apply(v);
      step();
      check($sformatf("sweep_f4_%0d", i), f4, ref4[v[4:1]]);
      check($sformatf("sweep_f5_%0d", i), f5, ref5[v]);
    end

    // Write the 4-var table while evaluating idx 6: same edge still old table.
    apply(5'b01101);
    tbl_we    = 1'b1;
    tbl_sel   = 1'b0;
    tbl_wdata = 32'h0000FFFF;
    step();
    tbl_we    = 1'b0;
    tbl_wdata = 32'hFFFFFFFF;  // must not leak without a strobe
    check("wr4_same_edge_f4", f4, 1'b0);
    check("wr4_same_edge_f5", f5, 1'b0);
    step();
    check("wr4_next_edge_f4", f4, 1'b1);
    check("wr4_f5_unaffected", f5, 1'b0);
    // 5-var table must still be default: idx 27 -> 1, idx 16 -> 1.
    apply(5'b11011);
    step();
    check("wr4_f5_default_27", f5, 1'b1);
    check("wr4_f4_new_13", f4, 1'b1);
    apply(5'b00000);
    step();
    check("wr4_f4_new_0", f4, 1'b1);
    check("wr4_f5_default_0", f5, 1'b0);

    // Write the 5-var table to all zeros; 4-var table keeps its new contents.
    apply(5'b11011);
    tbl_we    = 1'b1;
    tbl_sel   = 1'b1;
    tbl_wdata = 32'h0;
    step();
    tbl_we = 1'b0;
    check("wr5_same_edge_f5", f5, 1'b1);
    step();
    check("wr5_next_edge_f5", f5, 1'b0);
    check("wr5_f4_unaffected", f4, 1'b1);

    // Async reset mid-run: outputs drop without waiting for an edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_f4", f4, 1'b0);
    check("midrst_f5", f5, 1'b0);
    check("midrst_valid", valid, 1'b0);
    step();
    check("midrst_hold_f5", f5, 1'b0);
    check("midrst_hold_valid", valid, 1'b0);
    #2;
    rst_n = 1'b1;

    // Defaults restored in both tables.
    apply(5'b11011);
    step();
    check("post_rst_valid", valid, 1'b1);
    check("post_rst_f5_idx27", f5, 1'b1);
    apply(5'b01100);
    step();
    check("post_rst_f4_idx6", f4, 1'b0);
    check("post_rst_f5_idx12", f5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_kmap_eval
